// File: rtl/aes_pkg.sv
// aes_pkg: shared block sizes and feeder FSM state type for the AES datapath
package aes_pkg;
    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_BLOCK_BYTES = 16;
    typedef enum logic [1:0] {IDLE, CRST, SEND, WAIT_RES} feeder_state_t;
endpackage

// File: rtl/aes_pend_slot.sv
// aes_pend_slot: one-entry valid/ready holding register; a push and a pop in the same cycle
// replace the entry, and ready is registered so it is low while rst is held
module aes_pend_slot #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         pop
);
    logic push, valid_n;
    assign push    = in_valid && in_ready;
    assign valid_n = push || (out_valid && !pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            out_valid <= valid_n;
            in_ready  <= !valid_n;
        end
        if (push) out_data <= in_data;
    end
endmodule

// File: rtl/aes_block_feeder.sv
// aes_block_feeder: buffers one key/plaintext block and sequences the AES core through
// reset, a 16-byte MSB-first send and the wait for its result
module aes_block_feeder
    import aes_pkg::*;
#(
    parameter int WAIT_MAX = 4096,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AES_BLOCK_BITS-1:0] in_key,
    input  logic [AES_BLOCK_BITS-1:0] in_data,
    output logic                      core_rst,
    output logic                      enable,
    output logic [7:0]                key_byte,
    output logic [7:0]                state_byte,
    input  logic                      core_ready,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [CNT_W-1:0]          blocks_sent
);
    localparam int WT_W = $clog2(WAIT_MAX + 1);
    feeder_state_t state, state_n;
    logic [AES_BLOCK_BITS-1:0] key_sh, data_sh, key_sh_n, data_sh_n;
    logic [2*AES_BLOCK_BITS-1:0] pend_data;
    logic [3:0] byte_cnt, byte_cnt_n;
    logic [WT_W-1:0] wait_cnt, wait_cnt_n;
    logic pend_valid, pop, ready_q, complete, tmo, done;

    aes_pend_slot #(.W(2 * AES_BLOCK_BITS)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_key, in_data}),
        .out_valid (pend_valid),
        .out_data  (pend_data),
        .pop       (pop)
    );

    // completion is a falling edge of core_ready; timeout yields to a same-cycle completion
    assign complete = state == WAIT_RES && ready_q && !core_ready;
    assign tmo      = state == WAIT_RES && !complete && wait_cnt >= WT_W'(WAIT_MAX - 1);
    assign done     = complete || tmo;
    assign pop      = pend_valid && (state == IDLE || done);

    always_comb begin
        state_n    = state;
        key_sh_n   = key_sh;
        data_sh_n  = data_sh;
        byte_cnt_n = byte_cnt;
        wait_cnt_n = '0;
        if (pop) {key_sh_n, data_sh_n} = pend_data;
        case (state)
            IDLE:     state_n = pend_valid ? CRST : IDLE;
            CRST: begin
                state_n    = SEND;
                byte_cnt_n = '0;
            end
            SEND: begin
                byte_cnt_n = byte_cnt + 4'd1;
                key_sh_n   = key_sh << 8;
                data_sh_n  = data_sh << 8;
                state_n    = byte_cnt == 4'(AES_BLOCK_BYTES - 1) ? WAIT_RES : SEND;
            end
            WAIT_RES: begin
                wait_cnt_n = wait_cnt == WT_W'(WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
                state_n    = !done ? WAIT_RES : pend_valid ? CRST : IDLE;
            end
        endcase
    end

    // outputs are registered from next-state values so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            core_rst    <= 1'b0;
            enable      <= 1'b0;
            key_byte    <= '0;
            state_byte  <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            blocks_sent <= '0;
            ready_q     <= 1'b0;
            byte_cnt    <= '0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_n;
            core_rst    <= state_n == CRST;
            enable      <= state_n == SEND;
            key_byte    <= state_n == SEND ? key_sh_n[AES_BLOCK_BITS-1 -: 8] : 8'h00;
            state_byte  <= state_n == SEND ? data_sh_n[AES_BLOCK_BITS-1 -: 8] : 8'h00;
            busy        <= state_n != IDLE;
            timeout_err <= timeout_err || tmo;
            blocks_sent <= blocks_sent + CNT_W'(complete);
            ready_q     <= core_ready;
            byte_cnt    <= byte_cnt_n;
            wait_cnt    <= wait_cnt_n;
        end
        key_sh  <= key_sh_n;
        data_sh <= data_sh_n;
    end
endmodule
